layer_scheduler: RTL
====================

// Module: layer_scheduler
// PURPOSE
//  Sequences the DLA through a programmed list of layers.
//  - Holds a small table of 56-bit layer configurations, each in the DLA transfer_config format.
//  - Per layer: presents transfer_config, pulses DLA_start for one cycle, then waits for store_done
//    (psum buffer all-done) before advancing to the next layer.
//  - A watchdog flags a hung layer.
//  Sits between the host/config side and DLA/psum_buffer; it replaces the free-running reset-derived DLA_start.
// PARAMETERS
//  LAYER_MAX  8        table depth (max layers per run)
//  IDX_W      3        index width, = clog2(LAYER_MAX)
//  TO_W       20       watchdog counter width
//  TIMEOUT    20'hFFFFF  cycles allowed in WAIT before error; 0 disables the watchdog
// PORTS
//  clk              in   1       clock
//  rst              in   1       asynchronous reset, active-high
//  cfg_we           in   1       table write strobe
//  cfg_addr         in   IDX_W   table write/read index
//  cfg_wdata        in   56      layer configuration word
//  cfg_rdata        out  56      table[cfg_addr], combinational readback
//  num_layers       in   IDX_W+1 layers to run (0..LAYER_MAX), sampled at start
//  start            in   1       run request (level, sampled when not busy)
//  abort            in   1       terminate run
//  store_done       in   1       layer-complete pulse from psum buffer
//  DLA_start        out  1       one-cycle start pulse to DLA
//  transfer_config  out  56      current layer config to DLA
//  cur_layer        out  IDX_W   index of the layer in progress
//  busy             out  1       run in progress
//  done             out  1       one-cycle pulse, all layers finished
//  err              out  1       sticky watchdog error
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (DLA_start, transfer_config, cur_layer, busy, done, err);
//    table cleared to 0; run length n=0; watchdog 0.
//  - Table writes: accepted only when busy=0; ignored while busy. Write lands at the edge; cfg_rdata
//    shows the new value the next cycle.
//  - States: IDLE, LOAD, START, WAIT, NEXT, DONE, ERR.
//  - start is sampled in IDLE and ERR.
//    - Clears err. Latches n=num_layers. cur_layer<=0.
//    - n==0 -> DONE.
//    - n>LAYER_MAX is clamped to LAYER_MAX.
//    - Otherwise -> LOAD.
//  - LOAD (1 cycle): transfer_config<=table[cur_layer] -> START.
//    transfer_config holds stable until the next LOAD.
//  - START (1 cycle): DLA_start=1 (decoded from state, exactly one cycle) -> WAIT; watchdog<=0.
//  - WAIT:
//    - store_done=1 -> NEXT.
//    - Else watchdog++. When TIMEOUT!=0 and watchdog==TIMEOUT-1 -> ERR.
//    - store_done and timeout in the same cycle: store_done wins.
//  - store_done outside WAIT (including the START cycle) is ignored.
//  - NEXT (1 cycle):
//    - cur_layer==n-1 -> DONE.
//    - Else cur_layer++ -> LOAD.
//    - cur_layer never wraps.
//  - DONE (1 cycle): done=1 -> IDLE. cur_layer is held at its last value until the next start.
//  - ERR: err=1 sticky, busy=0. Leaves only on start (new run) or reset.
//  - busy=1 in LOAD, START, WAIT, NEXT; 0 in IDLE, DONE, ERR.
//  - abort:
//    - In any busy state -> IDLE next edge. Has priority over all other transitions.
//    - No done pulse. DLA_start is suppressed if the state was START.
//    - In IDLE, DONE or ERR it has no effect.
//    - abort and start together in IDLE: start wins (abort ignored when not busy).
//  - Latency: start high at edge k (IDLE) -> LOAD at k+1 -> DLA_start high in the cycle after edge k+2.
//    Per-layer overhead is 3 cycles (NEXT, LOAD, START) plus the WAIT time.
//  - Reset mid-run: immediate return to reset values (async). Table contents are lost.
// TESTING
//  1. Write 3 configs (0x11.., 0x22.., 0x33..), num_layers=3, start; store_done 10 cycles after each DLA_start
//     -> 3 single-cycle DLA_start pulses; transfer_config matches each entry; one done; busy low after it.
//  2. num_layers=0, start -> done 1 cycle after start; no DLA_start; busy stays 0.
//  3. TIMEOUT=16, never assert store_done -> err=1 on the 16th WAIT cycle; busy=0; a new start clears err
//     and reruns layer 0.
//  4. abort during layer 1 WAIT -> IDLE next cycle; no done; a store_done arriving later is ignored.
//  5. store_done asserted during the START cycle and the same cycle as timeout -> the first is ignored;
//     the second advances the run.
//  6. cfg_we while busy -> table is unchanged (cfg_rdata readback after the run); num_layers=9 clamps to 8 layers.

Source files
------------

// File: rtl/layer_scheduler.sv
// Layer sequencer for the DLA: walks a programmed table of transfer configs,
// issues one DLA_start per layer and waits for store_done, with a hang watchdog.
module layer_scheduler #(
    parameter int              LAYER_MAX = 8,
    parameter int              IDX_W     = 3,
    parameter int              TO_W      = 20,
    parameter logic [TO_W-1:0] TIMEOUT   = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [55:0]      cfg_wdata,
    output logic [55:0]      cfg_rdata,
    input  logic [IDX_W:0]   num_layers,
    input  logic             start,
    input  logic             abort,
    input  logic             store_done,
    output logic             DLA_start,
    output logic [55:0]      transfer_config,
    output logic [IDX_W-1:0] cur_layer,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int              CW      = IDX_W + 1;
    localparam logic [CW-1:0]   N_MAX   = CW'(LAYER_MAX);
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT, DONE, ERR} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    n_reg, n_next;
    logic [IDX_W-1:0] cur_reg, cur_next;
    logic [TO_W-1:0]  wd_reg, wd_next;
    logic [55:0]      tc_reg, tc_next;
    logic [55:0]      table_reg [LAYER_MAX];

    // Config table is only writable between runs so a layer cannot change under the DLA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAYER_MAX; i++) table_reg[i] <= '0;
        end else if (cfg_we && !busy) begin
            table_reg[cfg_addr] <= cfg_wdata;
        end
    end

    assign cfg_rdata = table_reg[cfg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            cur_reg   <= '0;
            wd_reg    <= '0;
            tc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            cur_reg   <= cur_next;
            wd_reg    <= wd_next;
            tc_reg    <= tc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        cur_next   = cur_reg;
        wd_next    = wd_reg;
        tc_next    = tc_reg;
        case (state_reg)
            IDLE, ERR: begin
                if (start) begin
                    cur_next   = '0;
                    n_next     = (num_layers > N_MAX) ? N_MAX : num_layers;
                    state_next = (num_layers == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                tc_next    = table_reg[cur_reg];
                state_next = START;
            end
            START: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // store_done beats a timeout landing in the same cycle
                if (store_done)
                    state_next = NEXT;
                else if (TIMEOUT != '0 && wd_reg == TO_LAST)
                    state_next = ERR;
                else
                    wd_next = wd_reg + TO_W'(1);
            end
            NEXT: begin
                if ({1'b0, cur_reg} == n_reg - CW'(1)) begin
                    state_next = DONE;
                end else begin
                    cur_next   = cur_reg + IDX_W'(1);
                    state_next = LOAD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (busy && abort) begin
            state_next = IDLE;
            cur_next   = cur_reg;
            wd_next    = wd_reg;
            tc_next    = tc_reg;
        end
    end

    assign busy            = (state_reg == LOAD) || (state_reg == START) ||
                             (state_reg == WAIT) || (state_reg == NEXT);
    assign DLA_start       = (state_reg == START) && !abort;
    assign done            = (state_reg == DONE);
    assign err             = (state_reg == ERR);
    assign transfer_config = tc_reg;
    assign cur_layer       = cur_reg;

endmodule
